// File: rtl/json_stream_arbiter.sv
// Object-granular round-robin arbiter sharing one JSON character parser between two sources.
// A stalled object owner is timed out and its object is closed by injected characters.
module json_stream_arbiter #(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_char,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_char,
  output logic       req1_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  output logic       out_src,
  output logic       busy,
  output logic       abort,
  output logic [7:0] obj_cnt0,
  output logic [7:0] obj_cnt1
);

  localparam int            TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [7:0]    CH_LBRACE = 8'h7B;
  localparam logic [7:0]    CH_RBRACE = 8'h7D;
  localparam logic [7:0]    CH_QUOTE  = 8'h22;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_LOCK    = 2'd1,
    ST_ABORT_Q = 2'd2,
    ST_ABORT_B = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          prio_r, prio_s;
  logic          owner_r, owner_s;
  logic          in_str_r, in_str_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [7:0]    cnt0_r, cnt0_s;
  logic [7:0]    cnt1_r, cnt1_s;
  logic          out_valid_r, out_valid_s;
  logic [7:0]    out_char_r, out_char_s;
  logic          out_src_r, out_src_s;
  logic          abort_r, abort_s;
  logic          busy_r;
  logic          ready0_s, ready1_s;
  logic          owner_valid_s;
  logic [7:0]    owner_char_s;
  logic          grant_s;
  logic [7:0]    grant_char_s;

  // Next-state, grant and output-register computation.
  always_comb begin
    state_s       = state_r;
    prio_s        = prio_r;
    owner_s       = owner_r;
    in_str_s      = in_str_r;
    timer_s       = timer_r;
    cnt0_s        = cnt0_r;
    cnt1_s        = cnt1_r;
    out_valid_s   = 1'b0;
    out_char_s    = FILL_CHAR;
    out_src_s     = 1'b0;
    abort_s       = 1'b0;
    ready0_s      = 1'b0;
    ready1_s      = 1'b0;
    grant_s       = 1'b0;
    grant_char_s  = FILL_CHAR;
    owner_valid_s = owner_r ? req1_valid : req0_valid;
    owner_char_s  = owner_r ? req1_char : req0_char;

    case (state_r)
      ST_OPEN: begin
        if (req0_valid && (!req1_valid || !prio_r)) begin
          ready0_s     = 1'b1;
          grant_s      = 1'b0;
          grant_char_s = req0_char;
        end else if (req1_valid) begin
          ready1_s     = 1'b1;
          grant_s      = 1'b1;
          grant_char_s = req1_char;
        end else begin
          grant_s      = 1'b0;
          grant_char_s = FILL_CHAR;
        end
        if (ready0_s || ready1_s) begin
          out_valid_s = 1'b1;
          out_char_s  = grant_char_s;
          out_src_s   = grant_s;
          prio_s      = ~grant_s;
          if (grant_char_s == CH_LBRACE) begin
            state_s  = ST_LOCK;
            owner_s  = grant_s;
            in_str_s = 1'b0;
            timer_s  = {TW{1'b0}};
          end else begin
            state_s = ST_OPEN;
          end
        end else begin
          state_s = ST_OPEN;
        end
      end

      ST_LOCK: begin
        if (owner_valid_s) begin
          ready0_s    = ~owner_r;
          ready1_s    = owner_r;
          out_valid_s = 1'b1;
          out_char_s  = owner_char_s;
          out_src_s   = owner_r;
          timer_s     = {TW{1'b0}};
          if (owner_char_s == CH_QUOTE) begin
            in_str_s = ~in_str_r;
          end else if ((owner_char_s == CH_RBRACE) && !in_str_r) begin
            // Normal close: count the object (saturating) and hand priority away.
            if (owner_r) begin
              cnt1_s = (cnt1_r == 8'hFF) ? cnt1_r : cnt1_r + 8'd1;
            end else begin
              cnt0_s = (cnt0_r == 8'hFF) ? cnt0_r : cnt0_r + 8'd1;
            end
            prio_s  = ~owner_r;
            state_s = ST_OPEN;
          end else begin
            state_s = ST_LOCK;
          end
        end else if (timer_r == TIMER_MAX) begin
          state_s = in_str_r ? ST_ABORT_Q : ST_ABORT_B;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end

      ST_ABORT_Q: begin
        out_valid_s = 1'b1;
        out_char_s  = CH_QUOTE;
        out_src_s   = owner_r;
        state_s     = ST_ABORT_B;
      end

      ST_ABORT_B: begin
        out_valid_s = 1'b1;
        out_char_s  = CH_RBRACE;
        out_src_s   = owner_r;
        abort_s     = 1'b1;
        prio_s      = ~owner_r;
        state_s     = ST_OPEN;
      end

      default: begin
        state_s = ST_OPEN;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_OPEN;
      prio_r      <= 1'b0;
      owner_r     <= 1'b0;
      in_str_r    <= 1'b0;
      timer_r     <= {TW{1'b0}};
      cnt0_r      <= 8'd0;
      cnt1_r      <= 8'd0;
      out_valid_r <= 1'b0;
      out_char_r  <= FILL_CHAR;
      out_src_r   <= 1'b0;
      abort_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      prio_r      <= prio_s;
      owner_r     <= owner_s;
      in_str_r    <= in_str_s;
      timer_r     <= timer_s;
      cnt0_r      <= cnt0_s;
      cnt1_r      <= cnt1_s;
      out_valid_r <= out_valid_s;
      out_char_r  <= out_char_s;
      out_src_r   <= out_src_s;
      abort_r     <= abort_s;
      busy_r      <= (state_s != ST_OPEN);
    end
  end

  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;
  assign out_valid  = out_valid_r;
  assign out_char   = out_char_r;
  assign out_src    = out_src_r;
  assign abort      = abort_r;
  assign busy       = busy_r;
  assign obj_cnt0   = cnt0_r;
  assign obj_cnt1   = cnt1_r;

endmodule

// File: tb/tb_json_stream_arbiter.sv
// Self-checking bench for json_stream_arbiter: directed scenarios plus random traffic,
// each cycle compared against an object/queue-level reference model.
module tb_json_stream_arbiter;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] LB = 8'h7B;
  localparam logic [7:0] RB = 8'h7D;
  localparam logic [7:0] QT = 8'h22;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_char = 8'h00, req1_char = 8'h00;
  logic       req0_ready, req1_ready, out_valid, out_src, busy, abort;
  logic [7:0] out_char, obj_cnt0, obj_cnt1;

  int total = 0;
  int passed = 0;

  // Reference model: an object is either open (locked) or not, plus a queue of characters
  // still to be injected when a stalled object is torn down.
  logic       m_locked, m_owner, m_quote, m_prio;
  int         m_stall;
  logic [7:0] m_cnt0, m_cnt1;
  logic [7:0] inj_q[$];

  json_stream_arbiter #(.FILL_CHAR(8'h20), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_char(out_char), .out_src(out_src),
    .busy(busy), .abort(abort), .obj_cnt0(obj_cnt0), .obj_cnt1(obj_cnt1)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked = 1'b0; m_owner = 1'b0; m_quote = 1'b0; m_prio = 1'b0;
    m_stall = 0; m_cnt0 = 8'd0; m_cnt1 = 8'd0;
    inj_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, predict, clock, return observed/expected
  // {ready0, ready1, out_valid, out_char, out_src, abort, busy, obj_cnt0, obj_cnt1}.
  task automatic step(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1,
                      output logic [29:0] obs, output logic [29:0] exp);
    logic r0, r1, ev, es, ea, g, ov;
    logic [7:0] ec, gc, oc;
    logic [1:0] obs_rdy;
    @(negedge clk);
    req0_valid = v0; req0_char = c0; req1_valid = v1; req1_char = c1;
    #1;
    obs_rdy = {req0_ready, req1_ready};
    r0 = 1'b0; r1 = 1'b0; ev = 1'b0; ec = 8'h20; es = 1'b0; ea = 1'b0;
    if (inj_q.size() != 0) begin
      ec = inj_q.pop_front(); ev = 1'b1; es = m_owner;
      if (inj_q.size() == 0) begin
        ea = 1'b1; m_locked = 1'b0; m_prio = !m_owner;
      end
    end else if (m_locked) begin
      ov = m_owner ? v1 : v0;
      oc = m_owner ? c1 : c0;
      if (ov) begin
        if (m_owner) r1 = 1'b1; else r0 = 1'b1;
        ev = 1'b1; ec = oc; es = m_owner; m_stall = 0;
        if (oc == QT) m_quote = !m_quote;
        else if (oc == RB && !m_quote) begin
          if (m_owner) m_cnt1 = (m_cnt1 == 8'd255) ? m_cnt1 : m_cnt1 + 8'd1;
          else         m_cnt0 = (m_cnt0 == 8'd255) ? m_cnt0 : m_cnt0 + 8'd1;
          m_locked = 1'b0; m_prio = !m_owner;
        end
      end else begin
        m_stall++;
        if (m_stall == TIMEOUT) begin
          if (m_quote) inj_q.push_back(QT);
          inj_q.push_back(RB);
          m_stall = 0;
        end
      end
    end else if (v0 || v1) begin
      g  = (v0 && v1) ? m_prio : v1;
      gc = g ? c1 : c0;
      if (g) r1 = 1'b1; else r0 = 1'b1;
      ev = 1'b1; ec = gc; es = g; m_prio = !g;
      if (gc == LB) begin
        m_locked = 1'b1; m_owner = g; m_quote = 1'b0; m_stall = 0;
      end
    end
    exp = {r0, r1, ev, ec, es, ea, (m_locked || inj_q.size() != 0), m_cnt0, m_cnt1};
    @(posedge clk);
    #1;
    obs = {obs_rdy, out_valid, out_char, out_src, abort, busy, obj_cnt0, obj_cnt1};
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({req0_ready, req1_ready, out_valid, out_char, out_src, abort, busy, obj_cnt0, obj_cnt1}
        !== {2'b00, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0})
      $display("FAIL reset: got v=%b c=%h s=%b a=%b b=%b n0=%0d n1=%0d required 0/20/0/0/0/0/0",
               out_valid, out_char, out_src, abort, busy, obj_cnt0, obj_cnt1);
    else passed++;
  endtask

  task automatic test_single_object();
    logic [7:0] seq [5] = '{LB, QT, 8'h61, QT, RB};
    logic [29:0] obs, exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0, 8'h00, obs, exp);
      total++;
      if (obs !== exp) $display("FAIL single_object[%0d]: got %h required %h", i, obs, exp);
      else passed++;
    end
    total++;
    if (obj_cnt0 !== 8'd1 || busy !== 1'b0)
      $display("FAIL single_object_count: got cnt=%0d busy=%b required 1/0", obj_cnt0, busy);
    else passed++;
  endtask

  task automatic test_lock_hold();
    logic [7:0] seq [4] = '{LB, 8'h61, 8'h62, RB};
    logic [29:0] obs, exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b1, 8'h7A, obs, exp);
      total++;
      if (obs !== exp || obs[28] !== 1'b0 || obs[18] !== 1'b0)
        $display("FAIL lock_hold[%0d]: got %h required %h", i, obs, exp);
      else passed++;
    end
    step(1'b1, 8'h71, 1'b1, 8'h7A, obs, exp);
    total++;
    if (obs !== exp || obs[28] !== 1'b1 || obs[18] !== 1'b1)
      $display("FAIL lock_hold_release: got %h required %h", obs, exp);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [29:0] obs, exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h78, 1'b1, 8'h79, obs, exp);
      total++;
      if (obs !== exp || obs[18] !== (i % 2 == 1) || obs[26:19] !== ((i % 2 == 1) ? 8'h79 : 8'h78))
        $display("FAIL round_robin[%0d]: got %h required %h", i, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_quoted_brace();
    logic [7:0] seq [9] = '{LB, QT, RB, QT, 8'h3A, QT, 8'h62, QT, RB};
    logic [29:0] obs, exp;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, seq[i], 1'b1, 8'h7A, obs, exp);
      total++;
      if (obs !== exp || (i < 8 && obs[16] !== 1'b1))
        $display("FAIL quoted_brace[%0d]: got %h required %h", i, obs, exp);
      else passed++;
    end
    total++;
    if (obj_cnt0 !== 8'd1 || busy !== 1'b0)
      $display("FAIL quoted_brace_count: got cnt=%0d busy=%b required 1/0", obj_cnt0, busy);
    else passed++;
  endtask

  // quote: open a string first; stall: owner-idle cycles; resume: owner sends 'm' afterwards.
  task automatic test_timeout(input string name, input logic quote, input int stall,
                              input logic resume, input int exp_aborts, input int exp_quotes,
                              input logic [7:0] exp_cnt);
    logic [29:0] obs, exp;
    int aborts = 0;
    int quotes = 0;
    do_reset();
    step(1'b1, LB, 1'b0, 8'h00, obs, exp);
    step(1'b1, quote ? QT : 8'h6A, 1'b0, 8'h00, obs, exp);
    step(1'b1, 8'h6B, 1'b0, 8'h00, obs, exp);
    for (int i = 0; i < stall + 4; i++) begin
      if (resume && i == stall) step(1'b1, 8'h6D, 1'b1, 8'h7A, obs, exp);
      else if (resume && i == stall + 1) step(1'b1, quote ? QT : 8'h6E, 1'b1, 8'h7A, obs, exp);
      else if (resume && i == stall + 2) step(1'b1, RB, 1'b1, 8'h7A, obs, exp);
      else step(1'b0, 8'h00, 1'b1, 8'h7A, obs, exp);
      if (obs[17]) aborts++;
      if (obs[27] && obs[26:19] == QT && obs[17:16] == 2'b01 && !obs[29]) quotes++;
      total++;
      if (obs !== exp) $display("FAIL %s[%0d]: got %h required %h", name, i, obs, exp);
      else passed++;
    end
    total++;
    if (aborts != exp_aborts || quotes != exp_quotes || obj_cnt0 !== exp_cnt)
      $display("FAIL %s_summary: got aborts=%0d quotes=%0d cnt=%0d required %0d/%0d/%0d",
               name, aborts, quotes, obj_cnt0, exp_aborts, exp_quotes, exp_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_object();
    logic [29:0] obs, exp;
    int stray = 0;
    do_reset();
    step(1'b1, LB, 1'b0, 8'h00, obs, exp);
    step(1'b1, QT, 1'b0, 8'h00, obs, exp);
    step(1'b1, 8'h73, 1'b0, 8'h00, obs, exp);
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b1; req0_char = 8'h71;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_char !== 8'h20 || obj_cnt0 !== 8'd0 || obj_cnt1 !== 8'd0 || busy !== 1'b0)
      $display("FAIL reset_mid_object: got v=%b c=%h n0=%0d n1=%0d b=%b required 0/20/0/0/0",
               out_valid, out_char, obj_cnt0, obj_cnt1, busy);
    else passed++;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, obs, exp);
      if (obs[27]) stray++;
    end
    total++;
    if (stray != 0) $display("FAIL reset_no_inject: got %0d outputs required 0", stray);
    else passed++;
  endtask

  task automatic test_saturation();
    logic [29:0] obs, exp;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 8'h00, 1'b1, LB, obs, exp);
      if (obs !== exp) bad++;
      step(1'b0, 8'h00, 1'b1, RB, obs, exp);
      if (obs !== exp) bad++;
    end
    total++;
    if (bad != 0 || obj_cnt1 !== 8'd255)
      $display("FAIL saturation: got cnt=%0d bad_cycles=%0d required 255/0", obj_cnt1, bad);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] tbl [5] = '{LB, RB, QT, 8'h61, 8'h62};
    logic [29:0] obs, exp;
    logic v0, v1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      v0 = ((i % 80) < 60) && ($urandom_range(3) != 0);
      v1 = ((i % 80) < 60) && ($urandom_range(3) != 0);
      step(v0, tbl[$urandom_range(4)], v1, tbl[$urandom_range(4)], obs, exp);
      total++;
      if (obs !== exp) $display("FAIL random[%0d]: got %h required %h", i, obs, exp);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_object();
    test_lock_hold();
    test_round_robin();
    test_quoted_brace();
    test_timeout("timeout_a", 1'b1, TIMEOUT, 1'b0, 1, 1, 8'd0);
    test_timeout("timeout_b", 1'b0, TIMEOUT, 1'b0, 1, 0, 8'd0);
    test_timeout("timeout_c", 1'b1, TIMEOUT - 1, 1'b1, 0, 0, 8'd1);
    test_reset_mid_object();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/json_stream_arbiter.md
Name: json_stream_arbiter

Overview:
- Shares one JSON character parser between two character sources (requesters 0 and 1).
- Grants the parser a whole object at a time: the owner holds the stream from '{' to its matching unquoted '}'. Outside objects, the stream is shared per character.
- Arbitration is round-robin between requesters.
- A stalled owner is timed out: the block closes the open object by injecting characters, then releases the stream.
- Output is registered and drives the parser's char input directly. FILL_CHAR is driven when no data is transferred.

Parameters:
- FILL_CHAR, 8'h20, character driven on out_char on idle cycles.
- TIMEOUT, 16, consecutive owner-stall cycles before abort; legal range ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 presents a character.
- req0_char  in  8  requester 0 character.
- req0_ready  out  1  requester 0 character accepted this cycle; combinational.
- req1_valid  in  1  requester 1 presents a character.
- req1_char  in  8  requester 1 character.
- req1_ready  out  1  requester 1 character accepted this cycle; combinational.
- out_valid  out  1  out_char carries a transferred or injected character; registered.
- out_char  out  8  character to the parser; registered.
- out_src  out  1  source of out_char; registered.
- busy  out  1  an object is locked, or an abort is in progress.
- abort  out  1  one-cycle pulse, registered with the injected '}'.
- obj_cnt0  out  8  objects completed normally by requester 0; saturating.
- obj_cnt1  out  8  objects completed normally by requester 1; saturating.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high, sampled on the posedge of clk.
- Reset values: state=OPEN, prio=0, in_str=0, timer=0, out_valid=0, out_char=FILL_CHAR, out_src=0, abort=0, obj_cnt0=obj_cnt1=0.
- Reset mid-object or mid-abort: everything is discarded. No characters are injected.
- Transfer rule: a transfer happens when reqN_valid & reqN_ready.
  - The transferred character appears on out_char one cycle later with out_valid=1.
  - On a non-transfer cycle, out_valid=0 and out_char=FILL_CHAR (unless a character is being injected).
  - At most one ready is high per cycle.
- State OPEN (no owner):
  - If exactly one requester is valid, grant it.
  - If both are valid, grant prio.
  - After a grant, prio ← the other requester.
  - If the granted character is '{': go to LOCK with owner ← granted requester, in_str←0, timer←0. Otherwise stay in OPEN.
- State LOCK:
  - Ready is asserted to the owner only: reqowner_ready = reqowner_valid. The non-owner's ready is 0.
  - An owner transfer of 8'h22 toggles in_str.
  - An owner transfer of '}' with in_str=0:
    - increment obj_cnt[owner], saturating at 255;
    - prio ← the other requester;
    - go to OPEN.
  - '}' with in_str=1 and '{' inside LOCK are forwarded as ordinary characters. There is no nesting.
  - Timer:
    - increments on each cycle the owner is not valid;
    - clears on every owner transfer;
    - when timer = TIMEOUT-1 and the owner is still not valid, go to ABORT_Q if in_str=1, else ABORT_B.
    - If the owner becomes valid on the cycle the timeout would fire, the transfer wins, the timer clears and the block stays in LOCK.
  - Timer width: enough bits to hold TIMEOUT-1.
- State ABORT_Q (one cycle):
  - Both readys are 0.
  - Registers out_valid=1, out_char=8'h22, out_src=owner.
  - Next state: ABORT_B.
- State ABORT_B (one cycle):
  - Both readys are 0.
  - Registers out_valid=1, out_char='}', out_src=owner, abort=1.
  - obj_cnt is not incremented.
  - prio ← the other requester.
  - Next state: OPEN.
- busy = (state ≠ OPEN).
- Counter saturation: obj_cnt at 255 holds 255 on further completions.

Test Plan:
- Single-source object: after reset, req0 sends '{','"','a','"','}' back-to-back. Required response:
  - req0_ready=1 every cycle;
  - out_char echoes each character one cycle later with out_src=0;
  - obj_cnt0=1; busy rises the cycle after the '{' transfer and falls after the '}' transfer.
- Lock hold: req0 opens '{' while req1_valid is held 1. Required response:
  - req1_ready=0 until req0's '}' transfers;
  - next cycle req1 is granted;
  - req1's characters never appear between req0's '{' and '}'.
- Round-robin: both requesters valid with non-'{' characters (e.g. 'x','y') for 4 cycles. Required response: grants alternate 0,1,0,1 and out_src alternates accordingly.
- Quoted brace: req0 sends '{','"','}','"',':','"','b','"','}'. Required response: only the final '}' unlocks, and obj_cnt0=1.
- Timeout abort, TIMEOUT=16:
  - Case A: req0 sends '{','"','k', then valid=0 for 16 cycles. Required response: out_char=8'h22, then '}' with abort=1 and out_src=0; state returns to OPEN; obj_cnt0 is unchanged.
  - Case B: same sequence with in_str=0 (no open quote). Required response: only '}' is injected.
  - Case C: valid returns on the 16th stall cycle. Required response: no abort occurs.
- Reset mid-object: reset is asserted while in LOCK with in_str=1. Required response, next cycle:
  - out_valid=0, out_char=8'h20;
  - both obj_cnt=0, busy=0;
  - no injection occurs.
